// File: rtl/parser_seg_collector_pkg.sv
// Shared parser definitions: collector FSM encoding, index-width helper and
// the default AXIS widths used across the parser stages.
package parser_seg_collector_pkg;

  localparam int AXIS_DATA_WIDTH_DFLT  = 512;
  localparam int AXIS_TUSER_WIDTH_DFLT = 128;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Segment index width, never narrower than one bit.
  function automatic int seg_idx_w(input int num_segs);
    return (num_segs > 2) ? $clog2(num_segs) : 1;
  endfunction

endpackage

// File: rtl/parser_seg_collector.sv
// Gathers the first C_NUM_SEGS beats of each AXIS packet into one wide bundle
// and hands it to the parser over a valid/ready handshake.
module parser_seg_collector
  import parser_seg_collector_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DFLT,
  parameter int C_AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH_DFLT,
  parameter int C_NUM_SEGS         = 4,
  parameter int C_SEG_CNT_W        = $clog2(C_NUM_SEGS + 1)
) (
  input  logic                                    axis_clk,
  input  logic                                    aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]          s_axis_tkeep,
  input  logic                                    s_axis_tvalid,
  input  logic                                    s_axis_tlast,
  output logic                                    s_axis_tready,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
  output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
  output logic [C_NUM_SEGS-1:0]                   segs_mask,
  output logic [C_SEG_CNT_W-1:0]                  segs_cnt,
  output logic                                    segs_valid,
  input  logic                                    segs_ready
);

  localparam int SEG_IDX_W = seg_idx_w(C_NUM_SEGS);
  localparam int BUNDLE_W  = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(C_NUM_SEGS - 1);
  localparam bit SINGLE_SEG = (C_NUM_SEGS == 1);

  logic [1:0]                    state_q, state_d;
  logic [SEG_IDX_W-1:0]          seg_idx_q, seg_idx_d;
  logic                          drain_pend_q, drain_pend_d;
  logic                          tready_q, tready_d;
  logic [BUNDLE_W-1:0]           tdata_q, tdata_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [C_NUM_SEGS-1:0]         mask_q, mask_d;
  logic [C_SEG_CNT_W-1:0]        cnt_q, cnt_d;
  logic                          valid_q, valid_d;
  logic                          beat_acc;
  logic                          tkeep_unused;

  // Bytes are captured raw, so keep has no effect on the bundle.
  assign tkeep_unused = ^s_axis_tkeep;
  assign beat_acc     = s_axis_tvalid & tready_q;

  // Next-state and capture logic for the collector FSM.
  always_comb begin
    state_d      = state_q;
    seg_idx_d    = seg_idx_q;
    drain_pend_d = drain_pend_q;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          tdata_d = '0;
          tdata_d[C_AXIS_DATA_WIDTH-1:0] = s_axis_tdata;
          tuser_d = s_axis_tuser;
          mask_d  = C_NUM_SEGS'(1);
          cnt_d   = C_SEG_CNT_W'(1);
          if (s_axis_tlast || SINGLE_SEG) begin
            state_d      = ST_HOLD;
            valid_d      = 1'b1;
            drain_pend_d = ~s_axis_tlast;
          end else begin
            state_d   = ST_COLLECT;
            seg_idx_d = SEG_IDX_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (beat_acc) begin
          tdata_d[seg_idx_q*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] = s_axis_tdata;
          mask_d[seg_idx_q] = 1'b1;
          cnt_d = cnt_q + C_SEG_CNT_W'(1);
          if (s_axis_tlast) begin
            state_d      = ST_HOLD;
            valid_d      = 1'b1;
            drain_pend_d = 1'b0;
          end else if (seg_idx_q == LAST_IDX) begin
            state_d      = ST_HOLD;
            valid_d      = 1'b1;
            drain_pend_d = 1'b1;
          end else begin
            seg_idx_d = seg_idx_q + SEG_IDX_W'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (valid_q && segs_ready) begin
          valid_d = 1'b0;
          state_d = drain_pend_q ? ST_DRAIN : ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // Beats past the last segment are swallowed until the packet ends.
        if (beat_acc && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    tready_d = (state_d != ST_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      seg_idx_q    <= '0;
      drain_pend_q <= 1'b0;
      tready_q     <= 1'b1;
      tdata_q      <= '0;
      tuser_q      <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_idx_q    <= seg_idx_d;
      drain_pend_q <= drain_pend_d;
      tready_q     <= tready_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign tdata_segs    = tdata_q;
  assign tuser_1st     = tuser_q;
  assign segs_mask     = mask_q;
  assign segs_cnt      = cnt_q;
  assign segs_valid    = valid_q;

endmodule

// File: tb/tb_parser_seg_collector.sv
// Directed testbench for parser_seg_collector with default parameters
// (512-bit beats, 128-bit tuser, 4 segments).
module tb_parser_seg_collector;

  localparam int W  = 512;
  localparam int U  = 128;
  localparam int N  = 4;
  localparam int CW = 3;

  logic             axis_clk = 1'b0;
  logic             aresetn = 1'b0;
  logic [W-1:0]     s_axis_tdata = '0;
  logic [U-1:0]     s_axis_tuser = '0;
  logic [W/8-1:0]   s_axis_tkeep = '1;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic [N*W-1:0]   tdata_segs;
  logic [U-1:0]     tuser_1st;
  logic [N-1:0]     segs_mask;
  logic [CW-1:0]    segs_cnt;
  logic             segs_valid;
  logic             segs_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 axis_clk = ~axis_clk;

  parser_seg_collector #(
    .C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U), .C_NUM_SEGS(N), .C_SEG_CNT_W(CW)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .tdata_segs(tdata_segs), .tuser_1st(tuser_1st), .segs_mask(segs_mask),
    .segs_cnt(segs_cnt), .segs_valid(segs_valid), .segs_ready(segs_ready)
  );

  function automatic logic [W-1:0] beat_val(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 ^ k;
    return {16{w}};
  endfunction

  function automatic logic [U-1:0] user_val(input int k);
    logic [31:0] w;
    w = 32'h5500_0000 + k;
    return {4{w}};
  endfunction

  // Expected segment i of a bundle holding n beats starting at base.
  function automatic logic [W-1:0] exp_seg(input int n, input int base, input int i);
    if (i < n) return beat_val(base + i);
    return '0;
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // Drives n beats; returns at #1 after the edge that accepted the last one.
  task automatic send_beats(input int n, input int base, input int user_k,
                            input bit last_on_final, input int gap);
    for (int i = 0; i < n; i++) begin
      int  waited;
      bit  acc;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_val(base + i);
      s_axis_tuser  = user_val(user_k + i);
      s_axis_tlast  = last_on_final && (i == n - 1);
      waited = 0;
      acc    = 1'b0;
      while (!acc && waited < 50) begin
        acc = s_axis_tready;
        tick();
        waited++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d of base %h not accepted in 50 cycles", i, base);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      for (int g = 0; g < gap && i < n - 1; g++) begin
        checks++;
        if (segs_valid !== 1'b0) begin errors++; $display("FAIL gap_valid: got %b required 0", segs_valid); end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(0, 0, i)) begin errors++; $display("FAIL rst_seg%0d: got %h required 0", i, tdata_segs[i*W +: W]); end
    end
    checks++; if (tuser_1st !== '0) begin errors++; $display("FAIL rst_tuser: got %h required 0", tuser_1st); end
    checks++; if (segs_mask !== 4'b0000) begin errors++; $display("FAIL rst_mask: got %b required 0000", segs_mask); end
    checks++; if (segs_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", segs_cnt); end
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", segs_valid); end
    aresetn = 1'b1;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b required 1", s_axis_tready); end
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_rel: got %b required 0", segs_valid); end
  endtask

  task automatic test_single_beat();
    segs_ready = 1'b1;
    send_beats(1, 32'h100, 1, 1'b1, 0);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", segs_valid); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL single_tready_hold: got %b required 0", s_axis_tready); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(1, 32'h100, i)) begin errors++; $display("FAIL single_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(1, 32'h100, i)); end
    end
    checks++; if (segs_mask !== 4'b0001) begin errors++; $display("FAIL single_mask: got %b required 0001", segs_mask); end
    checks++; if (segs_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d required 1", segs_cnt); end
    checks++; if (tuser_1st !== user_val(1)) begin errors++; $display("FAIL single_tuser: got %h required %h", tuser_1st, user_val(1)); end
    tick();
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b required 0", segs_valid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL single_tready_idle: got %b required 1", s_axis_tready); end
  endtask

  task automatic test_four_beat();
    send_beats(4, 32'h200, 2, 1'b1, 0);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL four_valid: got %b required 1", segs_valid); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(4, 32'h200, i)) begin errors++; $display("FAIL four_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(4, 32'h200, i)); end
    end
    checks++; if (segs_mask !== 4'b1111) begin errors++; $display("FAIL four_mask: got %b required 1111", segs_mask); end
    checks++; if (segs_cnt !== 3'd4) begin errors++; $display("FAIL four_cnt: got %0d required 4", segs_cnt); end
    checks++; if (tuser_1st !== user_val(2)) begin errors++; $display("FAIL four_tuser: got %h required %h", tuser_1st, user_val(2)); end
    tick();
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL four_valid_drop: got %b required 0", segs_valid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL four_tready_idle: got %b required 1", s_axis_tready); end
  endtask

  task automatic test_gaps();
    send_beats(3, 32'h300, 3, 1'b1, 2);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b required 1", segs_valid); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(3, 32'h300, i)) begin errors++; $display("FAIL gaps_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(3, 32'h300, i)); end
    end
    checks++; if (segs_mask !== 4'b0111) begin errors++; $display("FAIL gaps_mask: got %b required 0111", segs_mask); end
    checks++; if (segs_cnt !== 3'd3) begin errors++; $display("FAIL gaps_cnt: got %0d required 3", segs_cnt); end
    tick();
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL gaps_valid_drop: got %b required 0", segs_valid); end
  endtask

  task automatic test_drain();
    send_beats(4, 32'h400, 4, 1'b0, 0);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b required 1", segs_valid); end
    checks++; if (segs_cnt !== 3'd4) begin errors++; $display("FAIL drain_cnt: got %0d required 4", segs_cnt); end
    checks++; if (segs_mask !== 4'b1111) begin errors++; $display("FAIL drain_mask: got %b required 1111", segs_mask); end
    send_beats(3, 32'h404, 9, 1'b1, 0);
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL drain_no_valid: got %b required 0", segs_valid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL drain_tready: got %b required 1", s_axis_tready); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(4, 32'h400, i)) begin errors++; $display("FAIL drain_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(4, 32'h400, i)); end
    end
    send_beats(1, 32'h500, 5, 1'b1, 0);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL after_drain_valid: got %b required 1", segs_valid); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(1, 32'h500, i)) begin errors++; $display("FAIL after_drain_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(1, 32'h500, i)); end
    end
    checks++; if (segs_cnt !== 3'd1) begin errors++; $display("FAIL after_drain_cnt: got %0d required 1", segs_cnt); end
    checks++; if (tuser_1st !== user_val(5)) begin errors++; $display("FAIL after_drain_tuser: got %h required %h", tuser_1st, user_val(5)); end
    tick();
  endtask

  task automatic test_back_to_back();
    segs_ready = 1'b0;
    send_beats(2, 32'h600, 6, 1'b1, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = beat_val(32'h700);
    s_axis_tuser  = user_val(7);
    s_axis_tlast  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b required 1", c, segs_valid); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready c%0d: got %b required 0", c, s_axis_tready); end
      checks++; if (tdata_segs[W +: W] !== beat_val(32'h601)) begin errors++; $display("FAIL bp_seg1 c%0d: got %h required %h", c, tdata_segs[W +: W], beat_val(32'h601)); end
      checks++; if (segs_cnt !== 3'd2 || segs_mask !== 4'b0011) begin errors++; $display("FAIL bp_cnt_mask c%0d: got %0d/%b required 2/0011", c, segs_cnt, segs_mask); end
      tick();
    end
    segs_ready = 1'b1;
    tick();
    checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid: got %b required 0", segs_valid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_hs_tready: got %b required 1", s_axis_tready); end
    checks++; if (tdata_segs[0 +: W] !== beat_val(32'h600)) begin errors++; $display("FAIL bp_hs_seg0: got %h required %h", tdata_segs[0 +: W], beat_val(32'h600)); end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL bp2_valid: got %b required 1", segs_valid); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(1, 32'h700, i)) begin errors++; $display("FAIL bp2_seg%0d: got %h required %h", i, tdata_segs[i*W +: W], exp_seg(1, 32'h700, i)); end
    end
    checks++; if (tuser_1st !== user_val(7)) begin errors++; $display("FAIL bp2_tuser: got %h required %h", tuser_1st, user_val(7)); end
    tick();
  endtask

  task automatic test_reset_mid();
    segs_ready = 1'b1;
    send_beats(2, 32'h800, 8, 1'b0, 0);
    aresetn = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tdata_segs[i*W +: W] !== exp_seg(0, 0, i)) begin errors++; $display("FAIL mid_rst_seg%0d: got %h required 0", i, tdata_segs[i*W +: W]); end
    end
    checks++; if (segs_mask !== 4'b0000 || segs_cnt !== 3'd0) begin errors++; $display("FAIL mid_rst_mask_cnt: got %b/%0d required 0000/0", segs_mask, segs_cnt); end
    checks++; if (tuser_1st !== '0) begin errors++; $display("FAIL mid_rst_tuser: got %h required 0", tuser_1st); end
    aresetn = 1'b1;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL mid_rst_tready: got %b required 1", s_axis_tready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (segs_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid c%0d: got %b required 0", c, segs_valid); end
      tick();
    end
    send_beats(1, 32'h900, 9, 1'b1, 0);
    checks++; if (segs_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_new_valid: got %b required 1", segs_valid); end
    checks++; if (tdata_segs[0 +: W] !== beat_val(32'h900)) begin errors++; $display("FAIL mid_rst_new_seg0: got %h required %h", tdata_segs[0 +: W], beat_val(32'h900)); end
    checks++; if (segs_cnt !== 3'd1) begin errors++; $display("FAIL mid_rst_new_cnt: got %0d required 1", segs_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_gaps();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
